// File: rtl/tx_sched_ctrl.sv
// tx_sched_ctrl: transmit scheduler for the MAC TX path.
// Gates the start of each packet on a pending host length, enough data in
// the TX FIFO and an elapsed per-mode inter-packet gap. Stretches the gap
// after a configurable run of back-to-back packets and keeps the packet and
// byte statistics.
module tx_sched_ctrl #(
    parameter int FIFO_DEPTH_QWD = 32
) (
    input  logic        clk,
    input  logic        RESETN,
    input  logic        MODE_10G,
    input  logic        MODE_5G,
    input  logic        MODE_2P5G,
    input  logic        MODE_1G,
    input  logic        PKT_LEN_VLD,
    input  logic [12:0] PKT_LEN_QWD,
    output logic        PKT_LEN_ACK,
    input  logic [12:0] TXFIFO_WUSED_QWD,
    input  logic [5:0]  IPG_CFG,
    input  logic [5:0]  B2B_MAX,
    output logic        TX_START,
    input  logic        TX_DONE,
    input  logic [15:0] TX_DONE_BYTES,
    output logic        TX_BUSY,
    output logic [31:0] TX_PKT_SENT,
    output logic [31:0] TX_BYTE_SENT,
    output logic [5:0]  B2B_CNT,
    output logic [2:0]  SCHED_STATE,
    output logic        MODE_ERR,
    output logic        PROTO_ERR
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_START     = 3'd2,
        ST_XMIT      = 3'd3,
        ST_IPG       = 3'd4
    } state_t;

    // Start threshold can never exceed what the FIFO is able to hold.
    localparam logic [12:0] DEPTH_QWD = 13'(FIFO_DEPTH_QWD);

    state_t      state_reg,     state_next;
    logic [12:0] len_reg,       len_next;
    logic [3:0]  scale_reg,     scale_next;
    logic [10:0] ipg_cnt_reg,   ipg_cnt_next;
    logic [5:0]  b2b_cnt_reg,   b2b_cnt_next;
    logic [31:0] pkt_cnt_reg,   pkt_cnt_next;
    logic [31:0] byte_cnt_reg,  byte_cnt_next;
    logic        proto_err_reg, proto_err_next;
    logic        tx_start_reg,  tx_start_next;
    logic        busy_reg,      busy_next;

    logic [3:0]  mode_vec;
    logic [3:0]  mode_scale;
    logic        mode_err;
    logic [12:0] thr;
    logic        thr_met;
    logic [9:0]  gap_base;
    logic [6:0]  b2b_inc;
    logic        b2b_ext;
    logic [10:0] gap_total;

    assign mode_vec = {MODE_1G, MODE_2P5G, MODE_5G, MODE_10G};

    // Mode decode: gap multiplier for the selected speed, error unless one-hot.
    always_comb begin
        mode_scale = 4'd1;
        mode_err   = 1'b0;
        case (mode_vec)
            4'b0001: mode_scale = 4'd1;
            4'b0010: mode_scale = 4'd2;
            4'b0100: mode_scale = 4'd4;
            4'b1000: mode_scale = 4'd10;
            default: mode_err   = 1'b1;
        endcase
    end

    assign MODE_ERR = mode_err;

    // Start threshold: zero-length counts as one quadword, oversize packets
    // go cut-through once the FIFO is full.
    always_comb begin
        thr = len_reg;
        if (len_reg == 13'd0) begin
            thr = 13'd1;
        end else if (len_reg > DEPTH_QWD) begin
            thr = DEPTH_QWD;
        end
    end

    assign thr_met = (TXFIFO_WUSED_QWD >= thr);

    // Gap length for the packet just finished, doubled at the end of a
    // back-to-back run. Uses the mode latched when the packet was accepted.
    always_comb begin
        gap_base  = 10'(IPG_CFG) * 10'(scale_reg);
        b2b_inc   = {1'b0, b2b_cnt_reg} + 7'd1;
        b2b_ext   = (B2B_MAX != 6'd0) && (b2b_inc == {1'b0, B2B_MAX});
        gap_total = b2b_ext ? {gap_base, 1'b0} : {1'b0, gap_base};
    end

    // Scheduler next-state, statistics and registered-output decode.
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        scale_next     = scale_reg;
        ipg_cnt_next   = ipg_cnt_reg;
        b2b_cnt_next   = b2b_cnt_reg;
        pkt_cnt_next   = pkt_cnt_reg;
        byte_cnt_next  = byte_cnt_reg;
        proto_err_next = proto_err_reg;

        case (state_reg)
            ST_IDLE: begin
                // An empty host queue ends the back-to-back run.
                if (!PKT_LEN_VLD) begin
                    b2b_cnt_next = 6'd0;
                end
                if (!mode_err && PKT_LEN_VLD) begin
                    len_next   = PKT_LEN_QWD;
                    scale_next = mode_scale;
                    state_next = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (thr_met) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_XMIT;
            end
            ST_XMIT: begin
                if (TX_DONE) begin
                    pkt_cnt_next  = pkt_cnt_reg + 32'd1;
                    byte_cnt_next = byte_cnt_reg + {16'd0, TX_DONE_BYTES};
                    b2b_cnt_next  = b2b_ext ? 6'd0 : b2b_inc[5:0];
                    if (gap_total == 11'd0) begin
                        state_next = ST_IDLE;
                    end else begin
                        ipg_cnt_next = gap_total;
                        state_next   = ST_IPG;
                    end
                end
            end
            ST_IPG: begin
                // Counter holds the remaining cycles including this one.
                if (ipg_cnt_reg <= 11'd1) begin
                    ipg_cnt_next = 11'd0;
                    state_next   = ST_IDLE;
                end else begin
                    ipg_cnt_next = ipg_cnt_reg - 11'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // An end-of-packet outside XMIT is a handshake violation; it is
        // recorded but otherwise ignored.
        if (TX_DONE && (state_reg != ST_XMIT)) begin
            proto_err_next = 1'b1;
        end

        // Outputs are registered, so decode them from the upcoming state.
        tx_start_next = (state_next == ST_START);
        busy_next     = (state_next == ST_START) || (state_next == ST_XMIT);
    end

    // State and statistics registers.
    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            state_reg     <= ST_IDLE;
            len_reg       <= 13'd0;
            scale_reg     <= 4'd1;
            ipg_cnt_reg   <= 11'd0;
            b2b_cnt_reg   <= 6'd0;
            pkt_cnt_reg   <= 32'd0;
            byte_cnt_reg  <= 32'd0;
            proto_err_reg <= 1'b0;
            tx_start_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            scale_reg     <= scale_next;
            ipg_cnt_reg   <= ipg_cnt_next;
            b2b_cnt_reg   <= b2b_cnt_next;
            pkt_cnt_reg   <= pkt_cnt_next;
            byte_cnt_reg  <= byte_cnt_next;
            proto_err_reg <= proto_err_next;
            tx_start_reg  <= tx_start_next;
            busy_reg      <= busy_next;
        end
    end

    assign TX_START     = tx_start_reg;
    assign PKT_LEN_ACK  = tx_start_reg;
    assign TX_BUSY      = busy_reg;
    assign TX_PKT_SENT  = pkt_cnt_reg;
    assign TX_BYTE_SENT = byte_cnt_reg;
    assign B2B_CNT      = b2b_cnt_reg;
    assign SCHED_STATE  = state_reg;
    assign PROTO_ERR    = proto_err_reg;

endmodule

// File: doc/tx_sched_ctrl.md
# tx_sched_ctrl

Transmit scheduler for the MAC TX path. Decides when the TX engine may begin the next packet. Start conditions:
- a host packet length is pending;
- enough quadwords sit in the TX FIFO;
- the per-mode inter-packet gap has elapsed.

Also enforces an extended gap after a configurable run of back-to-back packets, and keeps the packet and byte sent statistics. Sits between the host write side and the TX framing engine, in front of the 32-entry TX FIFO.

## Interface
- FIFO_DEPTH_QWD, 32, TX FIFO capacity in quadwords; caps the start threshold.
- clk  in  1  single clock, rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- MODE_10G / MODE_5G / MODE_2P5G / MODE_1G  in  1 each  link speed, one-hot.
- PKT_LEN_VLD  in  1  head packet length valid (host side).
- PKT_LEN_QWD  in  13  head packet length in quadwords.
- PKT_LEN_ACK  out  1  one-cycle pop of the host length entry.
- TXFIFO_WUSED_QWD  in  13  FIFO occupancy in quadwords.
- IPG_CFG  in  6  base gap in cycles at 10G.
- B2B_MAX  in  6  back-to-back packets before an extended gap; 0 disables.
- TX_START  out  1  one-cycle start strobe to the TX engine.
- TX_DONE  in  1  one-cycle end-of-packet from the TX engine.
- TX_DONE_BYTES  in  16  byte count of the finished packet, valid with TX_DONE.
- TX_BUSY  out  1  high in START and XMIT.
- TX_PKT_SENT  out  32  packets completed.
- TX_BYTE_SENT  out  32  bytes completed.
- B2B_CNT  out  6  current back-to-back run length.
- SCHED_STATE  out  3  current state encoding.
- MODE_ERR  out  1  mode bits are not one-hot (combinational).
- PROTO_ERR  out  1  sticky; TX_DONE seen outside XMIT.

## Operation
States and encodings: IDLE=0, WAIT_DATA=1, START=2, XMIT=3, IPG=4.

IDLE
- If MODE_ERR, stay.
- Else if PKT_LEN_VLD: latch the length and mode, go to WAIT_DATA.
- If PKT_LEN_VLD is low for a cycle while in IDLE, clear B2B_CNT.

Threshold
- thr = max(1, min(latched length, FIFO_DEPTH_QWD)).
- A length of 0 counts as 1.
- A length above FIFO depth starts cut-through at a full FIFO.

WAIT_DATA
- When TXFIFO_WUSED_QWD >= thr, go to START.

START
- Assert TX_START and PKT_LEN_ACK for exactly one cycle, go to XMIT.

XMIT
- Wait for TX_DONE. On TX_DONE:
  - TX_PKT_SENT += 1.
  - TX_BYTE_SENT += {16'd0, TX_DONE_BYTES}. Both counters wrap mod 2^32.
  - B2B_CNT += 1.
  - Compute gap = IPG_CFG × scale, with scale 1 for 10G, 2 for 5G, 4 for 2.5G, 10 for 1G. Mode is the one latched in IDLE. Use a 10-bit counter (maximum 630).
  - If B2B_MAX != 0 and B2B_CNT + 1 == B2B_MAX: double the gap (11-bit, maximum 1260) and clear B2B_CNT.
  - If gap == 0, go to IDLE; else load the counter and go to IPG.

IPG
- Decrement every cycle; go to IDLE when the counter reaches 1.
- The gap is therefore exactly `gap` cycles in IPG.

Boundary and error rules
- TX_DONE in any state other than XMIT is ignored: counters and state unchanged, PROTO_ERR set until reset.
- IPG_CFG, B2B_MAX and mode changes take effect only at the next latch point: mode in IDLE, IPG_CFG and B2B_MAX at TX_DONE.
- MODE_ERR asserting after IDLE does not abort the packet in flight.
- PKT_LEN_VLD dropping in WAIT_DATA does not abort; the latched length is used.
- An asynchronous reset mid-packet returns to IDLE immediately. The TX engine must be reset by the same RESETN.

## Timing
- Reset values: state IDLE, TX_START 0, PKT_LEN_ACK 0, TX_BUSY 0, TX_PKT_SENT 0, TX_BYTE_SENT 0, B2B_CNT 0, PROTO_ERR 0, SCHED_STATE 0.
- Minimum latency from PKT_LEN_VLD rising (threshold already met) to TX_START: 2 cycles (IDLE → WAIT_DATA → START).
- TX_DONE cycle N: counters update at N+1, state is IPG or IDLE at N+1.
- Next TX_START occurs no earlier than N + gap + 3.
- TX_DONE arriving in the cycle immediately after TX_START is legal (1-cycle packet).
- All outputs are registered except MODE_ERR.

## Test plan
- 10G, IPG_CFG=12, B2B_MAX=0, WUSED=32, PKT_LEN_QWD=8 held valid, TX_DONE 20 cycles after each TX_START with 64 bytes → TX_START spacing 20+12+3 cycles; after 3 packets TX_PKT_SENT=3, TX_BYTE_SENT=192.
- 1G, IPG_CFG=12 → IPG lasts 120 cycles. IPG_CFG=0 → returns from XMIT straight to IDLE.
- B2B_MAX=2, 10G, IPG_CFG=5 → gaps 5, 10, 5, 10 cycles; B2B_CNT sequence 1, 0, 1, 0.
- PKT_LEN_QWD=40, FIFO_DEPTH_QWD=32, WUSED ramping 0..32 → TX_START only after WUSED=32. PKT_LEN_QWD=0 → start at WUSED=1.
- TX_DONE pulsed in IDLE → PROTO_ERR=1, counters unchanged. MODE_10G and MODE_1G both high → MODE_ERR=1, no TX_START.
- RESETN low during XMIT with TX_PKT_SENT=5 → immediate SCHED_STATE=0, TX_PKT_SENT=0, TX_BUSY=0.
